// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the PowerPC-to-Simulink register bank.
// Carries the OPB request signals (address, byte enables, write data,
// read/not-write, select, seqAddr) and the slave reply signals (read
// data, error/retry/timeout-suppress, transfer acknowledge). Vectors use
// the OPB big-endian numbering: bit 0 is the MSB, BE[0] covers DBus[0:7].
//   master modport : bus side, drives OPB_*, receives Sl_*
//   slave  modport : register bank side, receives OPB_*, drives Sl_*
interface opb_register_bank_ppc2simulink_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
  logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
  logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
  logic                      OPB_RNW;
  logic                      OPB_select;
  logic                      OPB_seqAddr;
  logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
  logic                      Sl_errAck;
  logic                      Sl_retry;
  logic                      Sl_toutSup;
  logic                      Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of C_NUM_REGS PowerPC-writable 32-bit control registers behind a
// single OPB slave window, with byte-lane writes, readback and a one-cycle
// update strobe per register. Registers flagged in C_PULSE_MASK are
// self-clearing: a written value is visible for one cycle only.
// Ports:
//   OPB_Clk        single clock for bus and registers
//   OPB_Rst        synchronous active-high reset
//   opb            OPB slave bundle (request in, reply out)
//   user_data_out  register i on bits [32i+31:32i]
//   user_update    bit i pulses for one cycle after register i is written
module opb_register_bank_ppc2simulink #(
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter logic [31:0] C_BASEADDR    = 32'h010B2400,
  parameter logic [31:0] C_HIGHADDR    = 32'h010B24FF,
  parameter int          C_NUM_REGS    = 4,
  parameter logic [63:0] C_PULSE_MASK  = 64'h0,
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000,
  parameter              C_FAMILY      = "virtex5"
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [C_NUM_REGS*32-1:0]     user_data_out,
  output logic [C_NUM_REGS-1:0]        user_update
);

  localparam int WW = C_OPB_AWIDTH - 2;

  typedef enum logic {IDLE, ACK} state_t;

  state_t                  state_q;
  logic [31:0]             regs_q [C_NUM_REGS];
  logic [31:0]             regs_d [C_NUM_REGS];
  logic [31:0]             rdata_q, rdata_d;
  logic [C_NUM_REGS-1:0]   update_q, update_d;

  logic [C_OPB_AWIDTH-1:0] abus_v;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic [WW-1:0]           word_idx;
  logic [31:0]             dbus_v;
  // be_v[3] is OPB_BE[0], i.e. the lane of the most significant byte.
  logic [3:0]              be_v;
  logic                    hit;
  logic                    accept;
  logic [C_NUM_REGS-1:0]   sel_onehot;
  logic [31:0]             sel_data;
  logic                    unused_ok;

  assign abus_v = opb.OPB_ABus;
  assign dbus_v = opb.OPB_DBus;
  assign be_v   = opb.OPB_BE;

  // Decode the window and the word index. The two address LSBs only pick
  // a byte inside a word, so they drop out of the index.
  always_comb begin
    hit        = opb.OPB_select && (abus_v >= C_BASEADDR) && (abus_v <= C_HIGHADDR);
    offset     = abus_v - C_BASEADDR;
    word_idx   = offset[C_OPB_AWIDTH-1:2];
    sel_onehot = '0;
    sel_data   = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (word_idx == WW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_data      = regs_q[i];
      end
    end
    // Only IDLE samples requests, so a held select is acked every other cycle.
    accept = (state_q == IDLE) && hit;
  end

  // Next register contents. Pulse registers fall back to zero every cycle
  // unless they are being written, which yields the one-cycle visibility.
  // An index past the last register matches no one-hot bit, so such a
  // write is dropped and a read returns zero while still being acked.
  always_comb begin
    for (int i = 0; i < C_NUM_REGS; i++) begin
      regs_d[i] = C_PULSE_MASK[i] ? 32'h0 : regs_q[i];
      if (accept && !opb.OPB_RNW && sel_onehot[i]) begin
        for (int b = 0; b < 4; b++) begin
          regs_d[i][8*b +: 8] = be_v[b] ? dbus_v[8*b +: 8] : regs_q[i][8*b +: 8];
        end
      end
    end
    update_d = (accept && !opb.OPB_RNW) ? sel_onehot : '0;
    rdata_d  = (accept && opb.OPB_RNW) ? sel_data : 32'h0;
  end

  // State and registered outputs. Reset wins over any transfer in flight.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      update_q <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs_q[i] <= C_PULSE_MASK[i] ? 32'h0 : C_RESET_VALUE;
      end
    end else begin
      case (state_q)
        IDLE:    state_q <= accept ? ACK : IDLE;
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      rdata_q  <= rdata_d;
      update_q <= update_d;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      user_data_out[32*i +: 32] = regs_q[i];
    end
  end

  assign user_update    = update_q;
  assign opb.Sl_xferAck = (state_q == ACK);
  assign opb.Sl_DBus    = rdata_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign unused_ok = ^{opb.OPB_seqAddr, offset[1:0], C_FAMILY, C_OPB_DWIDTH};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink: directed steps
// followed by random reads/writes, compared against a register-array model.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE   = 32'h010B2400;
  localparam logic [31:0] HIGH   = 32'h010B24FF;
  localparam logic [31:0] RSTVAL = 32'hA5A5A5A5;
  localparam logic [3:0]  PULSE  = 4'b0010;
  localparam int          NREGS  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] udo;
  logic [3:0]   upd;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_regs [NREGS];

  opb_register_bank_ppc2simulink_if bus ();

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR    (BASE),
    .C_HIGHADDR    (HIGH),
    .C_NUM_REGS    (NREGS),
    .C_PULSE_MASK  (64'h2),
    .C_RESET_VALUE (RSTVAL)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .opb           (bus),
    .user_data_out (udo),
    .user_update   (upd)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.OPB_select  = 1'b0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_seqAddr = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] model_udo();
    logic [127:0] r;
    for (int i = 0; i < NREGS; i++) r[32*i +: 32] = model_regs[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model_regs[i] = PULSE[i] ? 32'h0 : RSTVAL;
  endtask

  task automatic model_clear_pulses();
    for (int i = 0; i < NREGS; i++) if (PULSE[i]) model_regs[i] = 32'h0;
  endtask

  // Write transfer: be string is BE[0..3], BE[0] = most significant byte.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] data);
    bit         in_win;
    int         idx;
    logic [3:0] exp_upd;
    in_win  = (addr >= BASE) && (addr <= HIGH);
    idx     = int'((addr - BASE) >> 2);
    exp_upd = '0;
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_ABus   = addr;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = data;
    tick();
    bus_idle();
    if (in_win && idx < NREGS) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
      exp_upd[idx] = 1'b1;
    end
    check_output($sformatf("wr_ack@%h", addr), bus.Sl_xferAck, in_win);
    check_output($sformatf("wr_dbus@%h", addr), bus.Sl_DBus, 0);
    check_output($sformatf("wr_upd@%h", addr), upd, exp_upd);
    check_output($sformatf("wr_udo@%h", addr), udo, model_udo());
    model_clear_pulses();
    tick();
    check_output($sformatf("wr_ack_end@%h", addr), bus.Sl_xferAck, 0);
    check_output($sformatf("wr_upd_end@%h", addr), upd, 0);
    check_output($sformatf("wr_udo_end@%h", addr), udo, model_udo());
  endtask

  task automatic read_check(input logic [31:0] addr);
    bit          in_win;
    int          idx;
    logic [31:0] exp;
    in_win = (addr >= BASE) && (addr <= HIGH);
    idx    = int'((addr - BASE) >> 2);
    exp    = (in_win && idx < NREGS) ? model_regs[idx] : 32'h0;
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_ABus   = addr;
    bus.OPB_BE     = 4'b1111;
    tick();
    bus_idle();
    check_output($sformatf("rd_ack@%h", addr), bus.Sl_xferAck, in_win);
    check_output($sformatf("rd_data@%h", addr), bus.Sl_DBus, exp);
    tick();
    check_output($sformatf("rd_ack_end@%h", addr), bus.Sl_xferAck, 0);
    check_output($sformatf("rd_dbus_end@%h", addr), bus.Sl_DBus, 0);
  endtask

  initial begin
    int acks;
    rst = 1'b1;
    bus_idle();
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] reset state");
    check_output("rst_ack", bus.Sl_xferAck, 0);
    check_output("rst_dbus", bus.Sl_DBus, 0);
    check_output("rst_upd", upd, 0);
    check_output("rst_udo", udo, {RSTVAL, RSTVAL, 32'h0, RSTVAL});
    for (int i = 0; i < NREGS; i++) read_check(BASE + 32'(4*i));

    $display("[TB] full word write and readback");
    apply_stimulus(32'h010B2408, 4'b1111, 32'h12345678);
    check_output("reg2_value", udo[95:64], 32'h12345678);
    read_check(32'h010B2408);

    $display("[TB] byte lanes");
    apply_stimulus(32'h010B2400, 4'b1111, 32'hFFFFFFFF);
    apply_stimulus(32'h010B2400, 4'b0101, 32'h00000000);
    check_output("reg0_lanes", udo[31:0], 32'hFF00FF00);
    apply_stimulus(32'h010B240C, 4'b0000, 32'hDEADBEEF);
    read_check(32'h010B2400);

    $display("[TB] pulse register");
    apply_stimulus(32'h010B2404, 4'b1111, 32'h00000001);
    tick();
    read_check(32'h010B2404);

    $display("[TB] out of range and outside window");
    apply_stimulus(32'h010B2410, 4'b1111, 32'hCAFEF00D);
    read_check(32'h010B2410);
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_ABus   = 32'h010B2500;
    bus.OPB_BE     = 4'b1111;
    bus.OPB_DBus   = 32'h55AA55AA;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      acks += int'(bus.Sl_xferAck);
      check_output("outside_upd", upd, 0);
    end
    bus_idle();
    check_output("outside_acks", acks, 0);
    check_output("outside_udo", udo, model_udo());

    $display("[TB] reset during ack");
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_ABus   = 32'h010B2400;
    bus.OPB_BE     = 4'b1111;
    bus.OPB_DBus   = 32'h0BADF00D;
    tick();
    bus_idle();
    check_output("rstack_ack", bus.Sl_xferAck, 1);
    check_output("rstack_reg0", udo[31:0], 32'h0BADF00D);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_output("rstack_ack_after", bus.Sl_xferAck, 0);
    check_output("rstack_upd_after", upd, 0);
    check_output("rstack_udo_after", udo, model_udo());
    tick();
    check_output("rstack_upd_later", upd, 0);

    $display("[TB] held select");
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_ABus   = 32'h010B2400;
    bus.OPB_BE     = 4'b1111;
    acks = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      acks += int'(bus.Sl_xferAck);
      check_output($sformatf("held_ack_c%0d", c), bus.Sl_xferAck, (c % 2) == 1);
    end
    bus_idle();
    check_output("held_ack_count", acks, 3);
    tick();
    check_output("held_ack_after", bus.Sl_xferAck, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      logic [31:0] addr;
      addr = BASE + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        apply_stimulus(addr, 4'($urandom), $urandom);
      else
        read_check(addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single software-to-fabric register. It gives C_NUM_REGS 32-bit PowerPC-writable control registers behind one OPB slave window, with byte-lane writes and readback. Each register can be set as a level register or as a self-clearing pulse register, for strobes such as DAC start. Every register has a per-register update strobe. The block runs on a single clock with no CDC; it sits on the OPB bus next to the other Simulink-facing cores.

Parameters:
C_BASEADDR, 32'h010B2400, first byte address of window
C_HIGHADDR, 32'h010B24FF, last byte address of window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
C_NUM_REGS, 4, number of 32-bit registers (1..64)
C_PULSE_MASK, 0, bit i=1 makes register i a self-clearing pulse register
C_RESET_VALUE, 32'h00000000, reset value of every level register (pulse registers always reset to 0)
C_FAMILY, "virtex5", target family

Ports:
OPB_Clk  in  1  single clock for the bus and all registers
OPB_Rst  in  1  synchronous, active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7] (MSB byte)
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; 0 when not acking
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
user_data_out  out  [C_NUM_REGS*32-1:0]  register i at bits [32i+31:32i]
user_update  out  [C_NUM_REGS-1:0]  1-cycle strobe when register i has been written

Behaviour:
- Clock and reset: one clock, OPB_Clk; OPB_Rst is synchronous and active-high. Everything is sampled on the OPB_Clk rising edge.
- Reset values:
  - Sl_xferAck=0, Sl_DBus=0, user_update=0.
  - Level registers take C_RESET_VALUE; pulse registers take 0.
  - FSM goes to IDLE.
- Address hit: hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR).
  - idx = (OPB_ABus - C_BASEADDR) >> 2.
  - ABus[30:31] ignored.
- FSM states: IDLE, ACK.
  - IDLE -> ACK when hit is sampled in cycle T.
  - ACK lasts exactly one cycle (T+1), then returns to IDLE unconditionally.
  - A held OPB_select is therefore re-acked every other cycle; a request that drops before T+1 is still completed.
- ACK cycle: Sl_xferAck=1.
  - Read: Sl_DBus = reg[idx], captured at edge T.
  - Write: no Sl_DBus output (stays 0).
- Write commit at edge ending T: for each BE[k]=1, the matching byte of reg[idx] takes the matching OPB_DBus byte; other bytes are held.
  - user_data_out shows the new value from T+1.
  - user_update[idx]=1 during T+1 only, even if BE=0000.
- Pulse registers: the written value shows for exactly cycle T+1, then the register clears to 0 at edge ending T+1. Readback outside that cycle returns 0.
- Out-of-range idx (>= C_NUM_REGS but inside the window):
  - Transfer is acked normally.
  - Read returns 0; write is discarded with no user_update.
- Outside window: no response (xferAck stays 0).
- Sl_DBus is 0 in every non-ACK cycle (OR-bus requirement).
- Reset during ACK: next cycle xferAck=0, FSM=IDLE, registers at reset values, no user_update.
- Latency: request to ack is 1 cycle; write to user_data_out is 1 cycle.

Test Plan:
- Reset with C_RESET_VALUE=32'hA5A5A5A5, C_PULSE_MASK=4'b0010 -> reg0/2/3 read back A5A5A5A5, reg1 reads 0; xferAck=0 and Sl_DBus=0 while idle.
- Write 32'h12345678 to 0x010B2408 with BE=1111, then read it back -> user_data_out[95:64]=12345678; user_update=4'b0100 for one cycle; read returns 12345678; xferAck is high exactly one cycle per transfer.
- Byte lanes: reg0=FFFFFFFF, write 0x00000000 with BE=0101 -> reg0=FF00FF00; update strobe still fires.
- Pulse: write 1 to reg1 (0x010B2404) -> user_data_out[63:32]=1 for exactly one cycle, then 0; a read two cycles later returns 0.
- Out of range and outside window: write to 0x010B2410 -> acked, no user_update, read returns 0; access to 0x010B2500 -> no xferAck for 10 cycles.
- OPB_Rst asserted in the ACK cycle of a write -> xferAck=0 next cycle, register at reset value, user_update stays 0; select held 6 cycles -> exactly 3 acks.
